// File: rtl/j1_uart_io.sv
// j1 I/O-port UART: TX FIFO feeding an 8N1 serialiser, single-byte RX holding register,
// and the status/data word the core reads back as 'up'.
module j1_uart_io #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TXFIFO_LOG2  = 2
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_wr,
   input  logic [15:0] io_dout,
   output logic [15:0] up,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int DEPTH = 1 << TXFIFO_LOG2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]       BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]       HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TXFIFO_LOG2:0]   FIFO_DEPTH = (TXFIFO_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------- command decode
   logic wr_cmd, rx_ack;
   logic unused_io_bits;

   assign wr_cmd         = io_wr & ~io_dout[8];
   assign rx_ack         = io_wr &  io_dout[8];
   assign unused_io_bits = ^io_dout[15:9];

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]             fifo_mem [DEPTH];
   logic [TXFIFO_LOG2-1:0] wr_ptr, rd_ptr;
   logic [TXFIFO_LOG2:0]   fifo_count;
   logic                   fifo_empty, tx_full, fifo_push, tx_pop;

   tx_state_t        tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;

   assign fifo_empty = (fifo_count == '0);
   assign tx_full    = (fifo_count == FIFO_DEPTH);
   // The serialiser pops either from idle or at the very last stop-bit cycle (no gap).
   assign tx_pop     = !fifo_empty &&
                       (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == BIT_LAST));
   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   assign fifo_push  = wr_cmd && (!tx_full || tx_pop);

   always_ff @(posedge clk) begin
      if (fifo_push)
         fifo_mem[wr_ptr] <= io_dout[7:0];
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_push, tx_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---------------------------------------------------------------- TX FSM
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_shift <= fifo_mem[rd_ptr];
                  tx_cnt   <= '0;
                  uart_tx  <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  uart_tx  <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     uart_tx  <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     uart_tx  <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_pop) begin
                     tx_shift <= fifo_mem[rd_ptr];
                     uart_tx  <= 1'b0;
                     tx_state <= TX_START;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- RX path
   logic             rx_sync1, rx_sync2, rx_prev;
   rx_state_t        rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_shift;
   logic             rx_done;
   logic             rx_valid, rx_overrun;
   logic [7:0]       rx_data;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_sync1 <= 1'b1;
         rx_sync2 <= 1'b1;
         rx_prev  <= 1'b1;
      end else begin
         rx_sync1 <= uart_rx;
         rx_sync2 <= rx_sync1;
         rx_prev  <= rx_sync2;
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               // Edge-triggered so a line held low after a framing error cannot retrigger.
               if (rx_prev && !rx_sync2) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync2, rx_shift[7:1]};
                  if (rx_bit == 3'd7)
                     rx_state <= RX_STOP;
                  else
                     rx_bit <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign rx_done = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync2;

   // A delivery coinciding with an acknowledge behaves as ack-then-deliver.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         rx_data    <= '0;
      end else if (rx_done) begin
         if (!rx_valid || rx_ack) begin
            rx_data    <= rx_shift;
            rx_valid   <= 1'b1;
            rx_overrun <= 1'b0;
         end else begin
            rx_overrun <= 1'b1;
         end
      end else if (rx_ack) begin
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- status word
   logic tx_idle;
   assign tx_idle = fifo_empty && (tx_state == TX_IDLE);
   assign up      = {rx_valid, tx_full, tx_idle, rx_overrun, 4'h0, rx_data};

endmodule
